// File: rtl/pu_irq_ctrl_pkg.sv
// rtl/pu_irq_ctrl_pkg.sv - shared types and defaults for the PU interrupt controller
// Holds the request FSM state encoding and the default channel count.
package Pu_irq_types;

    localparam int N_CH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_REQ  = 2'd1,
        IRQ_HOLD = 2'd2
    } Irq_state;

endpackage

// File: rtl/pu_irq_arbiter.sv
// rtl/pu_irq_arbiter.sv - combinational winner select for eligible interrupt channels
// Ports:
//   i_eligible  N_CH  pending & enabled channels
//   i_ptr       ID_W  last granted id (round-robin only)
//   o_id        ID_W  winning channel id
//   o_valid     1     at least one channel eligible
module pu_irq_arbiter #(
    parameter int N_CH        = 8,
    parameter int ID_W        = 3,
    parameter int ROUND_ROBIN = 0
) (
    input  logic [N_CH-1:0] i_eligible,
    input  logic [ID_W-1:0] i_ptr,
    output logic [ID_W-1:0] o_id,
    output logic            o_valid
);

    logic [ID_W-1:0] w_fp_id;
    logic [ID_W-1:0] w_rr_id;
    int              w_d;
    int              w_best_d;

    always_comb begin
        w_fp_id  = '0;
        w_rr_id  = '0;
        w_d      = 0;
        w_best_d = N_CH;
        // Scanning downwards lets the lowest set index overwrite last.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (i_eligible[i]) begin
                w_fp_id = ID_W'(i);
            end
        end
        // Distance of each channel from ptr+1, modulo N_CH; the nearest wins.
        for (int i = 0; i < N_CH; i++) begin
            if (i_eligible[i]) begin
                w_d = (i - int'(i_ptr) - 1 + 2 * N_CH) % N_CH;
                if (w_d < w_best_d) begin
                    w_best_d = w_d;
                    w_rr_id  = ID_W'(i);
                end
            end
        end
        o_id    = (ROUND_ROBIN != 0) ? w_rr_id : w_fp_id;
        o_valid = |i_eligible;
    end

endmodule

// File: rtl/pu_irq_ctrl.sv
// rtl/pu_irq_ctrl.sv - external interrupt and wakeup controller for one processing unit
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   irq_in                raw per-channel requests
//   cfg_edge, cfg_mask    per-channel edge/level mode and enable
//   sw_clear              one-cycle clear of edge-mode pending bits
//   sleep, msr_ee         PU sleep state and external-interrupt enable
//   ext_input, ext_input_id, ext_input_ack   request/ack handshake to the PU
//   wakeup                wakeup for a sleeping PU
//   pending               pending vector for status readback
module pu_irq_ctrl
    import Pu_irq_types::*;
#(
    parameter int N_CH        = N_CH_DEFAULT,
    parameter int ID_W        = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int ROUND_ROBIN = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] irq_in,
    input  logic [N_CH-1:0] cfg_edge,
    input  logic [N_CH-1:0] cfg_mask,
    input  logic [N_CH-1:0] sw_clear,
    input  logic            sleep,
    input  logic            msr_ee,
    output logic            ext_input,
    output logic [ID_W-1:0] ext_input_id,
    input  logic            ext_input_ack,
    output logic            wakeup,
    output logic [N_CH-1:0] pending
);

    Irq_state        r_state;
    Irq_state        w_next_state;
    logic [N_CH-1:0] r_irq_q;
    logic [N_CH-1:0] r_pending;
    logic [N_CH-1:0] w_pending_nxt;
    logic [ID_W-1:0] r_id;
    logic [ID_W-1:0] r_ptr;
    logic            r_wakeup;
    logic [N_CH-1:0] w_edge;
    logic [N_CH-1:0] w_eligible;
    logic [ID_W-1:0] w_win_id;
    logic            w_win_valid;
    logic            w_ack_take;
    logic            w_latch_id;

    // r_irq_q resets to 0, so a request held high through reset is an edge.
    assign w_edge     = irq_in & ~r_irq_q;
    assign w_eligible = r_pending & cfg_mask;
    assign w_ack_take = (r_state == IRQ_REQ) && ext_input_ack;

    pu_irq_arbiter #(
        .N_CH       (N_CH),
        .ID_W       (ID_W),
        .ROUND_ROBIN(ROUND_ROBIN)
    ) u_arbiter (
        .i_eligible(w_eligible),
        .i_ptr     (r_ptr),
        .o_id      (w_win_id),
        .o_valid   (w_win_valid)
    );

    always_comb begin
        w_pending_nxt = r_pending;
        for (int i = 0; i < N_CH; i++) begin
            if (cfg_edge[i]) begin
                // A new edge beats a same-cycle clear so it is never lost.
                if (w_edge[i]) begin
                    w_pending_nxt[i] = 1'b1;
                end else if (sw_clear[i] || (w_ack_take && (r_id == ID_W'(i)))) begin
                    w_pending_nxt[i] = 1'b0;
                end
            end else begin
                w_pending_nxt[i] = irq_in[i];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_latch_id   = 1'b0;
        case (r_state)
            IRQ_IDLE: begin
                if (msr_ee && w_win_valid) begin
                    w_latch_id   = 1'b1;
                    w_next_state = IRQ_REQ;
                end
            end
            IRQ_REQ: begin
                if (ext_input_ack) begin
                    w_next_state = IRQ_HOLD;
                end else if (!w_eligible[r_id] || !msr_ee) begin
                    w_next_state = IRQ_IDLE;
                end
            end
            IRQ_HOLD: w_next_state = IRQ_IDLE;
            default:  w_next_state = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IRQ_IDLE;
            r_irq_q   <= '0;
            r_pending <= '0;
            r_id      <= '0;
            r_ptr     <= ID_W'(N_CH - 1);
            r_wakeup  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_irq_q   <= irq_in;
            r_pending <= w_pending_nxt;
            r_wakeup  <= sleep && (|w_eligible);
            if (w_latch_id) begin
                r_id <= w_win_id;
            end
            // Only an acknowledged grant advances the round-robin pointer.
            if (w_ack_take) begin
                r_ptr <= r_id;
            end
        end
    end

    assign ext_input    = (r_state == IRQ_REQ);
    assign ext_input_id = r_id;
    assign wakeup       = r_wakeup;
    assign pending      = r_pending;

endmodule

// File: tb/tb_pu_irq_ctrl.sv
// tb/tb_pu_irq_ctrl.sv - self-checking bench for pu_irq_ctrl (fixed and round-robin instances)
module tb_pu_irq_ctrl;

    localparam int N = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     irq, edg, msk, swc;
    logic             slp, ee;
    logic [1:0]       ack;
    logic [1:0]       o_ext;
    logic [1:0][2:0]  o_id;
    logic [1:0]       o_wake;
    logic [1:0][N-1:0] o_pend;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, one entry per instance (0 = fixed, 1 = round-robin).
    logic [N-1:0] m_irq_q;
    logic [N-1:0] m_pend [2];
    int           m_st   [2];   // 0 idle, 1 requesting, 2 hold
    int           m_id   [2];
    int           m_ptr  [2];
    bit           m_wake [2];

    always #5 clk = ~clk;

    pu_irq_ctrl #(.N_CH(N), .ROUND_ROBIN(0)) u_fp (
        .clk(clk), .reset(rst), .irq_in(irq), .cfg_edge(edg), .cfg_mask(msk),
        .sw_clear(swc), .sleep(slp), .msr_ee(ee), .ext_input(o_ext[0]),
        .ext_input_id(o_id[0]), .ext_input_ack(ack[0]), .wakeup(o_wake[0]),
        .pending(o_pend[0])
    );

    pu_irq_ctrl #(.N_CH(N), .ROUND_ROBIN(1)) u_rr (
        .clk(clk), .reset(rst), .irq_in(irq), .cfg_edge(edg), .cfg_mask(msk),
        .sw_clear(swc), .sleep(slp), .msr_ee(ee), .ext_input(o_ext[1]),
        .ext_input_id(o_id[1]), .ext_input_ack(ack[1]), .wakeup(o_wake[1]),
        .pending(o_pend[1])
    );

    function automatic int pick(int k, logic [N-1:0] e, int ptr);
        if (k == 0) begin
            for (int i = 0; i < N; i++) if (e[i]) return i;
        end else begin
            for (int off = 1; off <= N; off++) if (e[(ptr + off) % N]) return (ptr + off) % N;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_irq_q = '0;
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = '0; m_st[k] = 0; m_id[k] = 0; m_ptr[k] = N - 1; m_wake[k] = 0;
        end
    endtask

    task automatic model_update();
        logic [N-1:0] ev, elig, np;
        bit take;
        ev = irq & ~m_irq_q;
        for (int k = 0; k < 2; k++) begin
            elig = m_pend[k] & msk;
            take = (m_st[k] == 1) && ack[k];
            np = m_pend[k];
            for (int i = 0; i < N; i++) begin
                if (!edg[i])                               np[i] = irq[i];
                else if (ev[i])                            np[i] = 1'b1;
                else if (swc[i] || (take && m_id[k] == i)) np[i] = 1'b0;
            end
            m_wake[k] = slp && (elig != 0);
            if (m_st[k] == 0) begin
                if (ee && elig != 0) begin
                    m_id[k] = pick(k, elig, m_ptr[k]);
                    m_st[k] = 1;
                end
            end else if (m_st[k] == 1) begin
                if (take) begin
                    m_ptr[k] = m_id[k];
                    m_st[k] = 2;
                end else if (!elig[m_id[k]] || !ee) begin
                    m_st[k] = 0;
                end
            end else begin
                m_st[k] = 0;
            end
            m_pend[k] = np;
        end
        m_irq_q = irq;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_update();
        #1;
    endtask

    task automatic clear_inputs();
        irq = '0; edg = '1; msk = '1; swc = '0; slp = 1'b0; ee = 1'b0; ack = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic settle();
        irq = '0; ack = '0; ee = 1'b0; slp = 1'b0; swc = '1; edg = '1; msk = '1;
        repeat (4) step();
        swc = '0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        irq = 8'h01;
        model_reset();
        step();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_ext[k] !== 1'b0 || o_wake[k] !== 1'b0 || o_id[k] !== 3'd0 || o_pend[k] !== 8'h00) begin
                n_errors++;
                $display("FAIL reset_outputs[%0d]: got ext=%b wake=%b id=%0d pend=%h want 0 0 0 00",
                         k, o_ext[k], o_wake[k], o_id[k], o_pend[k]);
            end
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (o_pend[0] !== 8'h01) begin
            n_errors++;
            $display("FAIL reset_held_edge: got pend=%h want 01", o_pend[0]);
        end
        settle();
    endtask

    task automatic test_edge_fixed();
        settle();
        ee = 1'b1; irq = 8'h08;
        step();
        irq = '0;
        n_checks++;
        if (o_pend[0] !== 8'h08 || o_ext[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL edge_pending: got pend=%h ext=%b want 08 0", o_pend[0], o_ext[0]);
        end
        step();
        n_checks++;
        if (o_ext[0] !== 1'b1 || o_id[0] !== 3'd3) begin
            n_errors++;
            $display("FAIL edge_request: got ext=%b id=%0d want 1 3", o_ext[0], o_id[0]);
        end
        ack = 2'b01;
        step();
        ack = '0;
        n_checks++;
        if (o_pend[0] !== 8'h00 || o_ext[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL edge_ack: got pend=%h ext=%b want 00 0", o_pend[0], o_ext[0]);
        end
    endtask

    task automatic test_priority();
        settle();
        ee = 1'b1; irq = 8'h24;
        step();
        irq = '0;
        step();
        n_checks++;
        if (o_ext[0] !== 1'b1 || o_id[0] !== 3'd2) begin
            n_errors++;
            $display("FAIL prio_first: got ext=%b id=%0d want 1 2", o_ext[0], o_id[0]);
        end
        ack = 2'b01;
        step();
        ack = '0;
        n_checks++;
        if (o_ext[0] !== 1'b0 || o_pend[0] !== 8'h20) begin
            n_errors++;
            $display("FAIL prio_hold: got ext=%b pend=%h want 0 20", o_ext[0], o_pend[0]);
        end
        step();
        step();
        n_checks++;
        if (o_ext[0] !== 1'b1 || o_id[0] !== 3'd5) begin
            n_errors++;
            $display("FAIL prio_second: got ext=%b id=%0d want 1 5", o_ext[0], o_id[0]);
        end
        ack = 2'b01;
        step();
        ack = '0;
    endtask

    task automatic test_round_robin();
        int exp_ids [4] = '{0, 1, 7, 0};
        int w;
        apply_reset();
        edg = '0; ee = 1'b1; irq = 8'h83;
        for (int n = 0; n < 4; n++) begin
            w = 0;
            while (o_ext[1] !== 1'b1 && w < 10) begin
                step();
                w++;
            end
            n_checks++;
            if (o_ext[1] !== 1'b1 || o_id[1] !== 3'(exp_ids[n])) begin
                n_errors++;
                $display("FAIL rr_grant%0d: got ext=%b id=%0d want 1 %0d", n, o_ext[1], o_id[1], exp_ids[n]);
            end
            ack = 2'b10;
            step();
            ack = '0;
        end
        settle();
    endtask

    task automatic test_withdraw();
        int w;
        apply_reset();
        edg = '0; ee = 1'b1; irq = 8'h10;
        step();
        step();
        n_checks++;
        if (o_ext[1] !== 1'b1 || o_id[1] !== 3'd4) begin
            n_errors++;
            $display("FAIL withdraw_req: got ext=%b id=%0d want 1 4", o_ext[1], o_id[1]);
        end
        irq = '0;
        step();
        step();
        n_checks++;
        if (o_ext !== 2'b00) begin
            n_errors++;
            $display("FAIL withdraw_drop: got ext=%b want 00", o_ext);
        end
        irq = 8'h30;
        w = 0;
        while (o_ext[1] !== 1'b1 && w < 10) begin
            step();
            w++;
        end
        n_checks++;
        if (o_ext[1] !== 1'b1 || o_id[1] !== 3'd4) begin
            n_errors++;
            $display("FAIL withdraw_ptr: got ext=%b id=%0d want 1 4", o_ext[1], o_id[1]);
        end
        settle();
    endtask

    task automatic test_wakeup();
        settle();
        slp = 1'b1; ee = 1'b0; irq = 8'h40;
        step();
        irq = '0;
        n_checks++;
        if (o_wake[0] !== 1'b0 || o_pend[0] !== 8'h40) begin
            n_errors++;
            $display("FAIL wake_early: got wake=%b pend=%h want 0 40", o_wake[0], o_pend[0]);
        end
        step();
        n_checks++;
        if (o_wake[0] !== 1'b1 || o_ext[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL wake_set: got wake=%b ext=%b want 1 0", o_wake[0], o_ext[0]);
        end
        swc = 8'h40;
        step();
        swc = '0;
        n_checks++;
        if (o_wake[0] !== 1'b1 || o_pend[0] !== 8'h00) begin
            n_errors++;
            $display("FAIL wake_clear1: got wake=%b pend=%h want 1 00", o_wake[0], o_pend[0]);
        end
        step();
        n_checks++;
        if (o_wake[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL wake_clear2: got wake=%b want 0", o_wake[0]);
        end
        slp = 1'b0;
    endtask

    task automatic test_set_wins();
        settle();
        irq = 8'h02; swc = 8'h02;
        step();
        irq = '0; swc = '0;
        n_checks++;
        if (o_pend[0] !== 8'h02) begin
            n_errors++;
            $display("FAIL set_wins: got pend=%h want 02", o_pend[0]);
        end
    endtask

    task automatic test_reset_in_req();
        settle();
        ee = 1'b1; slp = 1'b1; irq = 8'h08;
        step();
        irq = '0;
        step();
        n_checks++;
        if (o_ext[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL rstreq_pre: got ext=%b want 1", o_ext[0]);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (o_ext !== 2'b00 || o_pend[0] !== 8'h00 || o_wake[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL rstreq_async: got ext=%b pend=%h wake=%b want 00 00 0", o_ext, o_pend[0], o_wake[0]);
        end
        model_reset();
        step();
        rst = 1'b0;
        slp = 1'b0; ee = 1'b0;
    endtask

    task automatic test_random();
        apply_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            irq = N'($urandom);
            if (cyc % 50 == 0) edg = N'($urandom);
            if (cyc % 37 == 0) msk = N'($urandom);
            swc = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            slp = 1'($urandom);
            ee  = ($urandom_range(0, 7) != 0);
            ack = 2'($urandom);
            step();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (o_ext[k] !== (m_st[k] == 1) || o_pend[k] !== m_pend[k] || o_wake[k] !== m_wake[k]) begin
                    n_errors++;
                    $display("FAIL rand[%0d] cyc %0d: got ext=%b pend=%h wake=%b want %b %h %b",
                             k, cyc, o_ext[k], o_pend[k], o_wake[k], (m_st[k] == 1), m_pend[k], m_wake[k]);
                end
                if (m_st[k] == 1) begin
                    n_checks++;
                    if (o_id[k] !== 3'(m_id[k])) begin
                        n_errors++;
                        $display("FAIL rand_id[%0d] cyc %0d: got %0d want %0d", k, cyc, o_id[k], m_id[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();
        test_reset();
        test_edge_fixed();
        test_priority();
        test_round_robin();
        test_withdraw();
        test_wakeup();
        test_set_wins();
        test_reset_in_req();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
